pmci_axi_id_tracker: RTL

//  Bridge between the PMCI subsystem AXI4 master port (which carries IDs) and the FIM AXI-lite CSR master (no IDs).
//  - Each accepted AWID/ARID is stored in a per-direction FIFO and returned in order on BID/RID.
//  - Supports up to MAX_OUTSTANDING outstanding requests per direction, in place of a single-request latch.
//  - Throttles the address channels when a tracker is full.
//  - Drains and flags orphan responses (responses with no tracked request).

---
 rtl/pmci_axi_id_tracker.sv | 158 +++++++++++++++
 1 files changed

// File: rtl/pmci_axi_id_tracker.sv
// AXI4 (with IDs) to AXI-lite bridge: remembers AWID/ARID in per-direction FIFOs and
// returns them in order on B/R, throttling address channels when a tracker is full.
module pmci_axi_id_tracker #(
  parameter int ID_W            = 8,
  parameter int ADDR_W          = 32,
  parameter int DATA_W          = 64,
  parameter int MAX_OUTSTANDING = 4
) (
  input  logic                               clk_csr,
  input  logic                               rst_n_csr,
  input  logic [ID_W-1:0]                    s_awid,
  input  logic [ADDR_W-1:0]                  s_awaddr,
  input  logic [2:0]                         s_awprot,
  input  logic                               s_awvalid,
  output logic                               s_awready,
  output logic [ADDR_W-1:0]                  m_awaddr,
  output logic [2:0]                         m_awprot,
  output logic                               m_awvalid,
  input  logic                               m_awready,
  input  logic [DATA_W-1:0]                  s_wdata,
  input  logic [DATA_W/8-1:0]                s_wstrb,
  input  logic                               s_wvalid,
  output logic                               s_wready,
  output logic [DATA_W-1:0]                  m_wdata,
  output logic [DATA_W/8-1:0]                m_wstrb,
  output logic                               m_wvalid,
  input  logic                               m_wready,
  output logic [ID_W-1:0]                    s_bid,
  output logic [1:0]                         s_bresp,
  output logic                               s_bvalid,
  input  logic                               s_bready,
  input  logic [1:0]                         m_bresp,
  input  logic                               m_bvalid,
  output logic                               m_bready,
  input  logic [ID_W-1:0]                    s_arid,
  input  logic [ADDR_W-1:0]                  s_araddr,
  input  logic [2:0]                         s_arprot,
  input  logic                               s_arvalid,
  output logic                               s_arready,
  output logic [ADDR_W-1:0]                  m_araddr,
  output logic [2:0]                         m_arprot,
  output logic                               m_arvalid,
  input  logic                               m_arready,
  output logic [ID_W-1:0]                    s_rid,
  output logic [DATA_W-1:0]                  s_rdata,
  output logic [1:0]                         s_rresp,
  output logic                               s_rlast,
  output logic                               s_rvalid,
  input  logic                               s_rready,
  input  logic [DATA_W-1:0]                  m_rdata,
  input  logic [1:0]                         m_rresp,
  input  logic                               m_rvalid,
  output logic                               m_rready,
  output logic [$clog2(MAX_OUTSTANDING):0]   outst_wr,
  output logic [$clog2(MAX_OUTSTANDING):0]   outst_rd,
  output logic                               err_orphan,
  input  logic                               err_clr
);

  localparam int CW = $clog2(MAX_OUTSTANDING) + 1;
  localparam int PW = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;

  logic [1:0]           rst_sync;
  logic                 rst_n;
  logic [1:0]           addr_valid, addr_ready, addr_fwd, addr_accept;
  logic [1:0]           resp_valid, resp_ready, resp_fwd, resp_drain;
  logic [1:0]           orphan;
  logic [1:0][ID_W-1:0] req_id, rsp_id;
  logic [1:0][CW-1:0]   outst;

  // Reset asserts immediately but releases on a clock edge.
  always_ff @(posedge clk_csr or negedge rst_n_csr) begin
    if (!rst_n_csr) rst_sync <= 2'b00;
    else            rst_sync <= {rst_sync[0], 1'b1};
  end
  assign rst_n = rst_sync[1];

  assign m_awaddr = s_awaddr;
  assign m_awprot = s_awprot;
  assign m_araddr = s_araddr;
  assign m_arprot = s_arprot;
  assign m_wdata  = s_wdata;
  assign m_wstrb  = s_wstrb;
  assign m_wvalid = s_wvalid;
  assign s_wready = m_wready;
  assign s_bresp  = m_bresp;
  assign s_rdata  = m_rdata;
  assign s_rresp  = m_rresp;
  assign s_rlast  = 1'b1;

  // Index 0 is the write tracker, index 1 the read tracker.
  assign addr_valid = {s_arvalid, s_awvalid};
  assign addr_ready = {m_arready, m_awready};
  assign resp_valid = {m_rvalid, m_bvalid};
  assign resp_ready = {s_rready, s_bready};
  assign req_id[0]  = s_awid;
  assign req_id[1]  = s_arid;

  for (genvar d = 0; d < 2; d++) begin : g_trk
    logic [ID_W-1:0] ids [MAX_OUTSTANDING];
    logic [PW-1:0]   wr_ptr, rd_ptr;
    logic [CW-1:0]   count;
    logic            full, empty, push, pop;

    assign full           = (count == CW'(MAX_OUTSTANDING));
    assign empty          = (count == '0);
    assign addr_fwd[d]    = addr_valid[d] & ~full;
    assign addr_accept[d] = addr_ready[d] & ~full;
    assign resp_fwd[d]    = resp_valid[d] & ~empty;
    assign resp_drain[d]  = empty | resp_ready[d];
    assign orphan[d]      = resp_valid[d] & empty;
    assign push           = addr_valid[d] & addr_accept[d];
    assign pop            = resp_fwd[d] & resp_ready[d];
    assign rsp_id[d]      = empty ? '0 : ids[rd_ptr];
    assign outst[d]       = count;

    always_ff @(posedge clk_csr or negedge rst_n) begin
      if (!rst_n) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
        count  <= '0;
      end else begin
        if (push) wr_ptr <= (wr_ptr == PW'(MAX_OUTSTANDING - 1)) ? '0 : wr_ptr + 1'b1;
        if (pop)  rd_ptr <= (rd_ptr == PW'(MAX_OUTSTANDING - 1)) ? '0 : rd_ptr + 1'b1;
        case ({push, pop})
          2'b10:   count <= count + 1'b1;
          2'b01:   count <= count - 1'b1;
          default: count <= count;
        endcase
      end
    end

    always_ff @(posedge clk_csr) begin
      if (push) ids[wr_ptr] <= req_id[d];
    end
  end

  assign m_awvalid = addr_fwd[0];
  assign s_awready = addr_accept[0];
  assign s_bvalid  = resp_fwd[0];
  assign m_bready  = resp_drain[0];
  assign s_bid     = rsp_id[0];
  assign m_arvalid = addr_fwd[1];
  assign s_arready = addr_accept[1];
  assign s_rvalid  = resp_fwd[1];
  assign m_rready  = resp_drain[1];
  assign s_rid     = rsp_id[1];
  assign outst_wr  = outst[0];
  assign outst_rd  = outst[1];

  // A new orphan wins over a same-cycle clear.
  always_ff @(posedge clk_csr or negedge rst_n) begin
    if (!rst_n)          err_orphan <= 1'b0;
    else if (|orphan)    err_orphan <= 1'b1;
    else if (err_clr)    err_orphan <= 1'b0;
  end

endmodule
